iaram_loader: RTL and testbench
===============================

# iaram_loader

Activation-side loader between the DRAM streamer and the PE input-activation RAM (IARAM). It accepts lane-parallel activation data and index beats, packs them per input channel into an internal banked buffer, and tracks per-channel lengths and dense/compressed mode. Once streaming finishes it presents a read port and per-channel metadata to the PE.

## Interface
Parameters:
- LANES, 4, beat width in elements (matches `num_of_data_Dram`)
- DATA_W, 16, activation width (signed)
- IDX_W, 4, index width (matches `bits_of_indices`)
- NUM_CH, 3, input channels buffered
- DEPTH, 64, entries per channel; power of two

Ports (clk and rst_n first):
- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- act_valid  in  LANES  per-lane data valid; set bits form a prefix (lane 0 upward)
- act_data  in  LANES*DATA_W  lane data
- act_channel  in  $clog2(NUM_CH)  channel of the data beat
- act_dense  in  1  beat belongs to a dense channel
- idx_valid  in  LANES  per-lane index valid; prefix rule as above
- idx_data  in  LANES*IDX_W  lane indices
- idx_channel  in  $clog2(NUM_CH)  channel of the index beat
- stream_finish  in  1  one-cycle pulse: the last beat is this cycle or the next one
- layer_release  in  1  PE done with buffer; clears it
- rd_en  in  1  PE read request
- rd_channel  in  $clog2(NUM_CH)  read channel
- rd_addr  in  $clog2(DEPTH)  read entry
- rd_data  out  DATA_W  registered read data
- rd_idx  out  IDX_W  registered read index (0 for dense channels)
- ch_len  out  NUM_CH*($clog2(DEPTH)+1)  per-channel element count
- ch_dense  out  NUM_CH  per-channel dense flag
- buf_ready  out  1  buffer complete and readable
- err_overflow  out  1  sticky: write beyond DEPTH
- err_mismatch  out  1  sticky: data/index count differ on a compressed channel

## Operation
- FSM has four states: IDLE, LOAD, DRAIN, READY.
  - IDLE to LOAD on the first beat with any valid bit.
  - LOAD to DRAIN on stream_finish.
  - DRAIN to READY after exactly one cycle. Beats are still accepted during DRAIN.
  - READY to IDLE on layer_release.
- Data write: popcount(act_valid) = n. Lane i writes entry data_cnt[ch]+i. data_cnt[ch] then increases by n. ch_dense[ch] is set to act_dense on the first beat of that channel.
- Index write: the same scheme using idx_cnt[ch].
- Data and index beats in the same cycle are independent. They may target different channels.
- Overflow: a lane whose address is at or above DEPTH is dropped and err_overflow is set. The counter saturates at DEPTH.
- Mismatch check on entry to READY: for every channel with ch_dense = 0 and data_cnt ≠ idx_cnt, err_mismatch is set.
- ch_len = data_cnt.
- Beats arriving in IDLE start a load. Beats arriving in READY are ignored and set err_overflow.
- rd_en is honoured only in READY. rd_addr ≥ ch_len[rd_channel] returns 0.
- layer_release:
  - Clears counters, dense flags and both error flags.
  - Storage contents are not cleared.
  - layer_release outside READY is ignored.
- stream_finish in IDLE with no beats goes through DRAIN to READY with all lengths 0.

## Timing
- Reset values: rd_data = 0, rd_idx = 0, ch_len = 0, ch_dense = 0, buf_ready = 0, err_* = 0, FSM = IDLE.
- Write to counter update takes 1 cycle. A written entry is readable in READY.
- Read latency is 1 cycle: rd_en at cycle t gives rd_data/rd_idx at t+1. Outputs hold their value when rd_en = 0.
- buf_ready rises 2 cycles after the stream_finish pulse, covering the cycle in DRAIN.
- buf_ready falls 1 cycle after layer_release.
- Asserting rst_n low mid-load immediately forces the reset values. The partial load is discarded.

## Structure
- Shared package holds:
  - typedef for the lane beat (valid/data/channel/dense)
  - typedef for the index beat
  - state enum
  - LANES, DATA_W, IDX_W constants, aligned with the DRAM stream package constants
- Sub-module `lane_compactor` computes popcount and per-lane write offsets for one beat. It is instantiated twice, once for data and once for indices.
- Storage uses per-channel register arrays, with a separate write-enable per lane.

## Test plan
- Channel 0 compressed: 6 data in beats of 4 and 2, then 6 indices; finish → ch_len[0] = 6, ch_dense[0] = 0, buf_ready after 2 cycles, reads of entries 0–5 match, err_* = 0.
- Channel 1 dense, 9 elements in beats of 4, 4, 1, with no indices → ch_len[1] = 9, ch_dense[1] = 1, rd_idx = 0, no err_mismatch.
- stream_finish one cycle before the last beat → that beat is stored and ch_len includes it.
- Channel 2: DEPTH+2 elements → 2 lanes dropped, ch_len[2] = 64, err_overflow = 1.
- Compressed channel with 5 data and 4 indices → err_mismatch = 1 at READY; layer_release clears it and returns to IDLE.
- rst_n low during LOAD (asynchronous, mid-cycle) → outputs go to reset values immediately; a new load then completes normally.

Source files
------------

// File: rtl/iaram_loader_pkg.sv
// Shared types and stream constants for the IARAM activation loader.
// LANES/DATA_W/IDX_W track the DRAM streamer's beat format.
package iaram_loader_pkg;

  localparam int LANES  = 4;
  localparam int DATA_W = 16;
  localparam int IDX_W  = 4;
  localparam int NUM_CH = 3;
  localparam int CH_W   = $clog2(NUM_CH);

  typedef struct packed {
    logic [LANES-1:0]        valid;
    logic [LANES*DATA_W-1:0] data;
    logic [CH_W-1:0]         channel;
    logic                    dense;
  } act_beat_t;

  typedef struct packed {
    logic [LANES-1:0]       valid;
    logic [LANES*IDX_W-1:0] data;
    logic [CH_W-1:0]        channel;
  } idx_beat_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DRAIN,
    ST_READY
  } state_t;

endpackage

// File: rtl/iaram_loader_lane_compactor.sv
// Popcount of a lane-valid mask plus the packed write offset of every lane.
// Offsets are exclusive prefix counts, so a sparse mask still packs densely.
module lane_compactor #(
  parameter int LANES = 4,
  parameter int OFF_W = $clog2(LANES + 1)
) (
  input  logic [LANES-1:0]       valid,
  output logic [OFF_W-1:0]       count,
  output logic [LANES*OFF_W-1:0] offset
);

  logic [OFF_W-1:0] run;

  always_comb begin
    run    = '0;
    offset = '0;
    for (int i = 0; i < LANES; i++) begin
      offset[i*OFF_W +: OFF_W] = run;
      run = run + OFF_W'(valid[i]);
    end
    count = run;
  end

endmodule

// File: rtl/iaram_loader.sv
// Packs activation/index beats per channel into banked storage and exposes
// a registered read port plus per-channel length/mode once streaming ends.
module iaram_loader #(
  parameter int LANES  = iaram_loader_pkg::LANES,
  parameter int DATA_W = iaram_loader_pkg::DATA_W,
  parameter int IDX_W  = iaram_loader_pkg::IDX_W,
  parameter int NUM_CH = iaram_loader_pkg::NUM_CH,
  parameter int DEPTH  = 64
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [LANES-1:0]                      act_valid,
  input  logic [LANES*DATA_W-1:0]               act_data,
  input  logic [$clog2(NUM_CH)-1:0]             act_channel,
  input  logic                                  act_dense,
  input  logic [LANES-1:0]                      idx_valid,
  input  logic [LANES*IDX_W-1:0]                idx_data,
  input  logic [$clog2(NUM_CH)-1:0]             idx_channel,
  input  logic                                  stream_finish,
  input  logic                                  layer_release,
  input  logic                                  rd_en,
  input  logic [$clog2(NUM_CH)-1:0]             rd_channel,
  input  logic [$clog2(DEPTH)-1:0]              rd_addr,
  output logic [DATA_W-1:0]                     rd_data,
  output logic [IDX_W-1:0]                      rd_idx,
  output logic [NUM_CH*($clog2(DEPTH)+1)-1:0]   ch_len,
  output logic [NUM_CH-1:0]                     ch_dense,
  output logic                                  buf_ready,
  output logic                                  err_overflow,
  output logic                                  err_mismatch
);

  import iaram_loader_pkg::*;

  localparam int CH_W   = $clog2(NUM_CH);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int LEN_W  = ADDR_W + 1;
  localparam int OFF_W  = $clog2(LANES + 1);
  localparam int SUM_W  = LEN_W + 1;
  localparam logic [SUM_W-1:0] DEPTH_S  = SUM_W'(DEPTH);
  localparam logic [LEN_W-1:0] DEPTH_L  = LEN_W'(DEPTH);
  localparam logic [CH_W:0]    CH_LIMIT = (CH_W+1)'(NUM_CH);

  state_t state, state_nxt;

  logic [LEN_W-1:0]  data_cnt [NUM_CH];
  logic [LEN_W-1:0]  data_cnt_nxt [NUM_CH];
  logic [LEN_W-1:0]  idx_cnt [NUM_CH];
  logic [LEN_W-1:0]  idx_cnt_nxt [NUM_CH];
  logic [NUM_CH-1:0] dense, dense_nxt;
  logic              err_ovf, err_ovf_nxt;
  logic              err_mis, err_mis_nxt;

  logic [DATA_W-1:0] data_mem [NUM_CH][DEPTH];
  logic [IDX_W-1:0]  idx_mem [NUM_CH][DEPTH];

  logic [LANES-1:0]  data_we, idx_we;
  logic [ADDR_W-1:0] data_waddr [LANES];
  logic [ADDR_W-1:0] idx_waddr [LANES];

  logic [OFF_W-1:0]       act_n, idx_n;
  logic [LANES*OFF_W-1:0] act_off, idx_off;

  logic             accept, act_any, idx_any, act_ch_ok, idx_ch_ok, rd_ch_ok;
  logic [SUM_W-1:0] act_base, act_addr, act_sum;
  logic [SUM_W-1:0] idx_base, idx_addr, idx_sum;
  logic [CH_W-1:0]  rd_ch;

  lane_compactor #(.LANES(LANES), .OFF_W(OFF_W)) u_act_compactor (
    .valid  (act_valid),
    .count  (act_n),
    .offset (act_off)
  );

  lane_compactor #(.LANES(LANES), .OFF_W(OFF_W)) u_idx_compactor (
    .valid  (idx_valid),
    .count  (idx_n),
    .offset (idx_off)
  );

  assign accept    = (state != ST_READY);
  assign act_any   = |act_valid;
  assign idx_any   = |idx_valid;
  assign act_ch_ok = ({1'b0, act_channel} < CH_LIMIT);
  assign idx_ch_ok = ({1'b0, idx_channel} < CH_LIMIT);

  always_comb begin
    state_nxt    = state;
    data_cnt_nxt = data_cnt;
    idx_cnt_nxt  = idx_cnt;
    dense_nxt    = dense;
    err_ovf_nxt  = err_ovf;
    err_mis_nxt  = err_mis;
    data_we      = '0;
    idx_we       = '0;
    act_base     = '0;
    act_addr     = '0;
    act_sum      = '0;
    idx_base     = '0;
    idx_addr     = '0;
    idx_sum      = '0;
    for (int i = 0; i < LANES; i++) begin
      data_waddr[i] = '0;
      idx_waddr[i]  = '0;
    end

    // Lanes landing at or past DEPTH are dropped; the count saturates.
    if (accept && act_ch_ok) begin
      act_base = {1'b0, data_cnt[act_channel]};
      for (int i = 0; i < LANES; i++) begin
        act_addr = act_base + SUM_W'(act_off[i*OFF_W +: OFF_W]);
        if (act_valid[i]) begin
          if (act_addr < DEPTH_S) begin
            data_we[i]    = 1'b1;
            data_waddr[i] = act_addr[ADDR_W-1:0];
          end else begin
            err_ovf_nxt = 1'b1;
          end
        end
      end
      act_sum = act_base + SUM_W'(act_n);
      data_cnt_nxt[act_channel] = (act_sum > DEPTH_S) ? DEPTH_L : act_sum[LEN_W-1:0];
      if (act_any && (data_cnt[act_channel] == '0)) begin
        dense_nxt[act_channel] = act_dense;
      end
    end else if (!accept && act_any) begin
      err_ovf_nxt = 1'b1;
    end

    if (accept && idx_ch_ok) begin
      idx_base = {1'b0, idx_cnt[idx_channel]};
      for (int i = 0; i < LANES; i++) begin
        idx_addr = idx_base + SUM_W'(idx_off[i*OFF_W +: OFF_W]);
        if (idx_valid[i]) begin
          if (idx_addr < DEPTH_S) begin
            idx_we[i]    = 1'b1;
            idx_waddr[i] = idx_addr[ADDR_W-1:0];
          end else begin
            err_ovf_nxt = 1'b1;
          end
        end
      end
      idx_sum = idx_base + SUM_W'(idx_n);
      idx_cnt_nxt[idx_channel] = (idx_sum > DEPTH_S) ? DEPTH_L : idx_sum[LEN_W-1:0];
    end else if (!accept && idx_any) begin
      err_ovf_nxt = 1'b1;
    end

    // The mismatch check uses next-cycle counts so a beat in DRAIN is included.
    case (state)
      ST_IDLE: begin
        if (stream_finish) begin
          state_nxt = ST_DRAIN;
        end else if (act_any || idx_any) begin
          state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (stream_finish) begin
          state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        state_nxt = ST_READY;
        for (int c = 0; c < NUM_CH; c++) begin
          if (!dense_nxt[c] && (data_cnt_nxt[c] != idx_cnt_nxt[c])) begin
            err_mis_nxt = 1'b1;
          end
        end
      end
      ST_READY: begin
        if (layer_release) begin
          state_nxt = ST_IDLE;
          for (int c = 0; c < NUM_CH; c++) begin
            data_cnt_nxt[c] = '0;
            idx_cnt_nxt[c]  = '0;
          end
          dense_nxt   = '0;
          err_ovf_nxt = 1'b0;
          err_mis_nxt = 1'b0;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      dense   <= '0;
      err_ovf <= 1'b0;
      err_mis <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        data_cnt[c] <= '0;
        idx_cnt[c]  <= '0;
      end
    end else begin
      state    <= state_nxt;
      dense    <= dense_nxt;
      err_ovf  <= err_ovf_nxt;
      err_mis  <= err_mis_nxt;
      data_cnt <= data_cnt_nxt;
      idx_cnt  <= idx_cnt_nxt;
    end
  end

  // Storage keeps its contents across reset and release; counts gate reads.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (data_we[i]) begin
        data_mem[act_channel][data_waddr[i]] <= act_data[i*DATA_W +: DATA_W];
      end
      if (idx_we[i]) begin
        idx_mem[idx_channel][idx_waddr[i]] <= idx_data[i*IDX_W +: IDX_W];
      end
    end
  end

  assign rd_ch_ok = ({1'b0, rd_channel} < CH_LIMIT);
  assign rd_ch    = rd_ch_ok ? rd_channel : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
      rd_idx  <= '0;
    end else if (rd_en && (state == ST_READY)) begin
      if (rd_ch_ok && ({1'b0, rd_addr} < data_cnt[rd_ch])) begin
        rd_data <= data_mem[rd_ch][rd_addr];
        rd_idx  <= dense[rd_ch] ? '0 : idx_mem[rd_ch][rd_addr];
      end else begin
        rd_data <= '0;
        rd_idx  <= '0;
      end
    end
  end

  always_comb begin
    ch_len = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      ch_len[c*LEN_W +: LEN_W] = data_cnt[c];
    end
  end

  assign ch_dense     = dense;
  assign buf_ready    = (state == ST_READY);
  assign err_overflow = err_ovf;
  assign err_mismatch = err_mis;

endmodule

// File: tb/tb_iaram_loader.sv
// Directed bench for iaram_loader: one task per scenario, inline checks
// against hand-computed values, single summary line at the end.
module tb_iaram_loader;

  localparam int LANES  = 4;
  localparam int DATA_W = 16;
  localparam int IDX_W  = 4;
  localparam int NUM_CH = 3;
  localparam int DEPTH  = 64;
  localparam int CH_W   = 2;
  localparam int ADDR_W = 6;
  localparam int LEN_W  = 7;

  logic                      clk;
  logic                      rst_n;
  logic [LANES-1:0]          act_valid;
  logic [LANES*DATA_W-1:0]   act_data;
  logic [CH_W-1:0]           act_channel;
  logic                      act_dense;
  logic [LANES-1:0]          idx_valid;
  logic [LANES*IDX_W-1:0]    idx_data;
  logic [CH_W-1:0]           idx_channel;
  logic                      stream_finish;
  logic                      layer_release;
  logic                      rd_en;
  logic [CH_W-1:0]           rd_channel;
  logic [ADDR_W-1:0]         rd_addr;
  logic [DATA_W-1:0]         rd_data;
  logic [IDX_W-1:0]          rd_idx;
  logic [NUM_CH*LEN_W-1:0]   ch_len;
  logic [NUM_CH-1:0]         ch_dense;
  logic                      buf_ready;
  logic                      err_overflow;
  logic                      err_mismatch;

  int total = 0;
  int bad   = 0;

  iaram_loader #(
    .LANES(LANES), .DATA_W(DATA_W), .IDX_W(IDX_W), .NUM_CH(NUM_CH), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .act_valid(act_valid), .act_data(act_data), .act_channel(act_channel), .act_dense(act_dense),
    .idx_valid(idx_valid), .idx_data(idx_data), .idx_channel(idx_channel),
    .stream_finish(stream_finish), .layer_release(layer_release),
    .rd_en(rd_en), .rd_channel(rd_channel), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_idx(rd_idx), .ch_len(ch_len), .ch_dense(ch_dense),
    .buf_ready(buf_ready), .err_overflow(err_overflow), .err_mismatch(err_mismatch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int len_of(input int c);
    return int'(ch_len[c*LEN_W +: LEN_W]);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    act_valid     = '0;
    act_data      = '0;
    act_channel   = '0;
    act_dense     = 1'b0;
    idx_valid     = '0;
    idx_data      = '0;
    idx_channel   = '0;
    stream_finish = 1'b0;
    layer_release = 1'b0;
    rd_en         = 1'b0;
    rd_channel    = '0;
    rd_addr       = '0;
  endtask

  task automatic set_act(input int ch, input int n, input logic dense, input int base);
    act_valid   = '0;
    act_channel = CH_W'(ch);
    act_dense   = dense;
    for (int i = 0; i < LANES; i++) begin
      if (i < n) begin
        act_valid[i] = 1'b1;
        act_data[i*DATA_W +: DATA_W] = DATA_W'(base + i);
      end
    end
  endtask

  task automatic set_idx(input int ch, input int n, input int base);
    idx_valid   = '0;
    idx_channel = CH_W'(ch);
    for (int i = 0; i < LANES; i++) begin
      if (i < n) begin
        idx_valid[i] = 1'b1;
        idx_data[i*IDX_W +: IDX_W] = IDX_W'(base + i);
      end
    end
  endtask

  task automatic beat();
    tick();
    act_valid = '0;
    idx_valid = '0;
  endtask

  task automatic pulse_finish();
    stream_finish = 1'b1;
    tick();
    stream_finish = 1'b0;
  endtask

  task automatic pulse_release();
    layer_release = 1'b1;
    tick();
    layer_release = 1'b0;
  endtask

  task automatic do_read(input int ch, input int addr);
    rd_en      = 1'b1;
    rd_channel = CH_W'(ch);
    rd_addr    = ADDR_W'(addr);
    tick();
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    total++; if (rd_data !== 16'd0) begin bad++; $display("[TB] FAIL reset_rd_data: got %0d want 0", rd_data); end
    total++; if (rd_idx !== 4'd0) begin bad++; $display("[TB] FAIL reset_rd_idx: got %0d want 0", rd_idx); end
    total++; if (ch_len !== '0) begin bad++; $display("[TB] FAIL reset_ch_len: got %h want 0", ch_len); end
    total++; if (ch_dense !== 3'b000) begin bad++; $display("[TB] FAIL reset_ch_dense: got %b want 000", ch_dense); end
    total++; if (buf_ready !== 1'b0) begin bad++; $display("[TB] FAIL reset_buf_ready: got %b want 0", buf_ready); end
    total++; if ({err_overflow, err_mismatch} !== 2'b00) begin bad++; $display("[TB] FAIL reset_err: got %b want 00", {err_overflow, err_mismatch}); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_compressed();
    set_act(0, 4, 1'b0, 100); beat();
    set_act(0, 2, 1'b0, 104); beat();
    set_idx(0, 4, 1); beat();
    set_idx(0, 2, 5); beat();
    pulse_finish();
    total++; if (buf_ready !== 1'b0) begin bad++; $display("[TB] FAIL comp_ready_drain: got %b want 0", buf_ready); end
    tick();
    total++; if (buf_ready !== 1'b1) begin bad++; $display("[TB] FAIL comp_ready: got %b want 1", buf_ready); end
    total++; if (len_of(0) !== 6) begin bad++; $display("[TB] FAIL comp_len: got %0d want 6", len_of(0)); end
    total++; if (ch_dense[0] !== 1'b0) begin bad++; $display("[TB] FAIL comp_dense: got %b want 0", ch_dense[0]); end
    total++; if ({err_overflow, err_mismatch} !== 2'b00) begin bad++; $display("[TB] FAIL comp_err: got %b want 00", {err_overflow, err_mismatch}); end
    for (int i = 0; i < 6; i++) begin
      do_read(0, i);
      total++; if (rd_data !== DATA_W'(100 + i)) begin bad++; $display("[TB] FAIL comp_rd_data[%0d]: got %0d want %0d", i, rd_data, 100 + i); end
      total++; if (rd_idx !== IDX_W'(1 + i)) begin bad++; $display("[TB] FAIL comp_rd_idx[%0d]: got %0d want %0d", i, rd_idx, 1 + i); end
    end
    tick();
    total++; if (rd_data !== 16'd105) begin bad++; $display("[TB] FAIL comp_rd_hold: got %0d want 105", rd_data); end
    do_read(0, 6);
    total++; if (rd_data !== 16'd0) begin bad++; $display("[TB] FAIL comp_rd_past_len: got %0d want 0", rd_data); end
    do_read(0, 2);
    total++; if (rd_data !== 16'd102) begin bad++; $display("[TB] FAIL comp_rd_again: got %0d want 102", rd_data); end
    pulse_release();
    total++; if (buf_ready !== 1'b0) begin bad++; $display("[TB] FAIL comp_release_ready: got %b want 0", buf_ready); end
    total++; if (len_of(0) !== 0) begin bad++; $display("[TB] FAIL comp_release_len: got %0d want 0", len_of(0)); end
    do_read(0, 0);
    total++; if (rd_data !== 16'd102) begin bad++; $display("[TB] FAIL comp_rd_idle_ignored: got %0d want 102", rd_data); end
  endtask

  task automatic test_dense();
    set_act(1, 4, 1'b1, 200); beat();
    set_act(1, 4, 1'b1, 204); beat();
    set_act(1, 1, 1'b1, 208); beat();
    pulse_finish();
    tick();
    total++; if (buf_ready !== 1'b1) begin bad++; $display("[TB] FAIL dense_ready: got %b want 1", buf_ready); end
    total++; if (len_of(1) !== 9) begin bad++; $display("[TB] FAIL dense_len: got %0d want 9", len_of(1)); end
    total++; if (ch_dense !== 3'b010) begin bad++; $display("[TB] FAIL dense_flag: got %b want 010", ch_dense); end
    total++; if (err_mismatch !== 1'b0) begin bad++; $display("[TB] FAIL dense_mismatch: got %b want 0", err_mismatch); end
    for (int i = 0; i < 9; i += 4) begin
      do_read(1, i);
      total++; if (rd_data !== DATA_W'(200 + i)) begin bad++; $display("[TB] FAIL dense_rd_data[%0d]: got %0d want %0d", i, rd_data, 200 + i); end
      total++; if (rd_idx !== 4'd0) begin bad++; $display("[TB] FAIL dense_rd_idx[%0d]: got %0d want 0", i, rd_idx); end
    end
    do_read(1, 9);
    total++; if (rd_data !== 16'd0) begin bad++; $display("[TB] FAIL dense_rd_past_len: got %0d want 0", rd_data); end
    set_act(1, 1, 1'b1, 999); beat();
    total++; if (err_overflow !== 1'b1) begin bad++; $display("[TB] FAIL ready_beat_err: got %b want 1", err_overflow); end
    total++; if (len_of(1) !== 9) begin bad++; $display("[TB] FAIL ready_beat_len: got %0d want 9", len_of(1)); end
    pulse_release();
    total++; if (err_overflow !== 1'b0) begin bad++; $display("[TB] FAIL dense_release_err: got %b want 0", err_overflow); end
  endtask

  task automatic test_late_beat();
    set_act(0, 4, 1'b0, 300); set_idx(0, 4, 2); beat();
    pulse_finish();
    set_act(0, 2, 1'b0, 304); set_idx(0, 2, 6); beat();
    total++; if (buf_ready !== 1'b1) begin bad++; $display("[TB] FAIL late_ready: got %b want 1", buf_ready); end
    total++; if (len_of(0) !== 6) begin bad++; $display("[TB] FAIL late_len: got %0d want 6", len_of(0)); end
    total++; if ({err_overflow, err_mismatch} !== 2'b00) begin bad++; $display("[TB] FAIL late_err: got %b want 00", {err_overflow, err_mismatch}); end
    do_read(0, 5);
    total++; if (rd_data !== 16'd305) begin bad++; $display("[TB] FAIL late_rd_data: got %0d want 305", rd_data); end
    total++; if (rd_idx !== 4'd7) begin bad++; $display("[TB] FAIL late_rd_idx: got %0d want 7", rd_idx); end
    pulse_release();
  endtask

  task automatic test_overflow();
    for (int k = 0; k < 16; k++) begin
      set_act(2, 4, 1'b1, 4 * k); beat();
    end
    total++; if (err_overflow !== 1'b0) begin bad++; $display("[TB] FAIL ovf_at_depth_err: got %b want 0", err_overflow); end
    total++; if (len_of(2) !== 64) begin bad++; $display("[TB] FAIL ovf_at_depth_len: got %0d want 64", len_of(2)); end
    set_act(2, 2, 1'b1, 64); beat();
    total++; if (err_overflow !== 1'b1) begin bad++; $display("[TB] FAIL ovf_err: got %b want 1", err_overflow); end
    pulse_finish();
    tick();
    total++; if (len_of(2) !== 64) begin bad++; $display("[TB] FAIL ovf_len: got %0d want 64", len_of(2)); end
    total++; if (err_mismatch !== 1'b0) begin bad++; $display("[TB] FAIL ovf_mismatch: got %b want 0", err_mismatch); end
    do_read(2, 63);
    total++; if (rd_data !== 16'd63) begin bad++; $display("[TB] FAIL ovf_rd_last: got %0d want 63", rd_data); end
    pulse_release();
    total++; if (err_overflow !== 1'b0) begin bad++; $display("[TB] FAIL ovf_release_err: got %b want 0", err_overflow); end
  endtask

  task automatic test_mismatch();
    set_act(1, 4, 1'b0, 10); beat();
    set_act(1, 1, 1'b0, 14); set_idx(1, 4, 0); beat();
    pulse_release();
    total++; if (len_of(1) !== 5) begin bad++; $display("[TB] FAIL release_in_load_len: got %0d want 5", len_of(1)); end
    pulse_finish();
    tick();
    total++; if (buf_ready !== 1'b1) begin bad++; $display("[TB] FAIL mis_ready: got %b want 1", buf_ready); end
    total++; if (err_mismatch !== 1'b1) begin bad++; $display("[TB] FAIL mis_err: got %b want 1", err_mismatch); end
    total++; if (err_overflow !== 1'b0) begin bad++; $display("[TB] FAIL mis_ovf: got %b want 0", err_overflow); end
    pulse_release();
    total++; if (err_mismatch !== 1'b0) begin bad++; $display("[TB] FAIL mis_release_err: got %b want 0", err_mismatch); end
    total++; if (buf_ready !== 1'b0) begin bad++; $display("[TB] FAIL mis_release_ready: got %b want 0", buf_ready); end
  endtask

  task automatic test_empty_finish();
    pulse_finish();
    total++; if (buf_ready !== 1'b0) begin bad++; $display("[TB] FAIL empty_drain_ready: got %b want 0", buf_ready); end
    tick();
    total++; if (buf_ready !== 1'b1) begin bad++; $display("[TB] FAIL empty_ready: got %b want 1", buf_ready); end
    total++; if (ch_len !== '0) begin bad++; $display("[TB] FAIL empty_len: got %h want 0", ch_len); end
    total++; if (err_mismatch !== 1'b0) begin bad++; $display("[TB] FAIL empty_mismatch: got %b want 0", err_mismatch); end
    pulse_release();
  endtask

  task automatic test_reset_midload();
    do_read(0, 0);
    set_act(0, 4, 1'b1, 500); beat();
    total++; if (len_of(0) !== 4) begin bad++; $display("[TB] FAIL midload_len_before: got %0d want 4", len_of(0)); end
    total++; if (ch_dense[0] !== 1'b1) begin bad++; $display("[TB] FAIL midload_dense_before: got %b want 1", ch_dense[0]); end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (len_of(0) !== 0) begin bad++; $display("[TB] FAIL midload_len: got %0d want 0", len_of(0)); end
    total++; if (ch_dense !== 3'b000) begin bad++; $display("[TB] FAIL midload_dense: got %b want 000", ch_dense); end
    total++; if (rd_data !== 16'd0) begin bad++; $display("[TB] FAIL midload_rd_data: got %0d want 0", rd_data); end
    total++; if (buf_ready !== 1'b0) begin bad++; $display("[TB] FAIL midload_ready: got %b want 0", buf_ready); end
    #2;
    rst_n = 1'b1;
    tick();
    set_act(0, 2, 1'b0, 600); set_idx(0, 2, 9); beat();
    pulse_finish();
    tick();
    total++; if (buf_ready !== 1'b1) begin bad++; $display("[TB] FAIL reload_ready: got %b want 1", buf_ready); end
    total++; if (len_of(0) !== 2) begin bad++; $display("[TB] FAIL reload_len: got %0d want 2", len_of(0)); end
    total++; if ({err_overflow, err_mismatch} !== 2'b00) begin bad++; $display("[TB] FAIL reload_err: got %b want 00", {err_overflow, err_mismatch}); end
    do_read(0, 1);
    total++; if (rd_data !== 16'd601) begin bad++; $display("[TB] FAIL reload_rd_data: got %0d want 601", rd_data); end
    total++; if (rd_idx !== 4'd10) begin bad++; $display("[TB] FAIL reload_rd_idx: got %0d want 10", rd_idx); end
    pulse_release();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_compressed();
    test_dense();
    test_late_beat();
    test_overflow();
    test_mismatch();
    test_empty_finish();
    test_reset_midload();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
